piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parametrised parallel-in/serial-out converter with valid/ready handshake.
//   Accepts an N-bit word, then shifts it out MSB- or LSB-first, holding each bit for CLKS_PER_BIT clocks.
//   Supports gapless back-to-back frames and provides frame-start and frame-done strobes.
//   Sits between word-oriented producers and bit-serial links (SPI-style TX, LED/shift-register chains).
// PARAMETERS
//   N            8  data word width in bits; N >= 2
//   CLKS_PER_BIT 1  clock cycles each bit is held on o_serial; >= 1
//   IDLE_LEVEL   0  value driven on o_serial while no frame is active
// PORTS
//   clk          in   1  sole clock; all state updates on posedge
//   rst          in   1  asynchronous, active-high reset
//   i_valid      in   1  i_data/i_direction valid this cycle
//   o_ready      out  1  block can accept a word this cycle
//   i_data       in   N  parallel word to serialise
//   i_direction  in   1  0 = MSB_FIRST, 1 = LSB_FIRST; sampled only on accept
//   o_serial     out  1  serial bit stream
//   o_first      out  1  high for the entire period of bit 0 of each frame
//   o_busy       out  1  high while a frame is being shifted out
//   o_done       out  1  one-cycle pulse in the final clock of the last bit
// BEHAVIOUR
//   Reset (async, any time, including mid-frame):
//     state=IDLE, shift reg=0, counters=0.
//     o_serial=IDLE_LEVEL, o_first=0, o_busy=0, o_done=0, o_ready=1.
//     The partial frame is discarded.
//   FSM states: IDLE, SHIFT.
//   Accept = i_valid & o_ready at a posedge.
//     On accept: load shift reg <= i_data, latch dir <= i_direction, bit_cnt <= 0, div_cnt <= 0; go to SHIFT.
//   Latency: accept at edge k -> bit 0 on o_serial from edge k through edge k+CLKS_PER_BIT.
//     A frame occupies exactly N*CLKS_PER_BIT cycles.
//   SHIFT:
//     o_serial = sreg[N-1] if dir==MSB_FIRST, else sreg[0].
//     o_busy=1; o_first = (bit_cnt==0).
//     div_cnt counts 0..CLKS_PER_BIT-1; at terminal count it wraps to 0, bit_cnt increments, and sreg shifts:
//       MSB_FIRST: left, 0 fills bit 0.
//       LSB_FIRST: right, 0 fills bit N-1.
//     last = (bit_cnt==N-1) & (div_cnt==CLKS_PER_BIT-1); o_done = last.
//   o_ready = (state==IDLE) | last.
//     Accept while last -> reload immediately, no idle gap (gapless stream); o_first rises next cycle.
//     last without accept -> go to IDLE; o_serial returns to IDLE_LEVEL next cycle.
//   i_valid while busy and not last: ignored. No data is lost because o_ready=0.
//   i_direction/i_data changes mid-frame: no effect on the frame in flight.
//   Counter widths: $clog2(N) for bit_cnt, max(1,$clog2(CLKS_PER_BIT)) for div_cnt; no overflow beyond terminal counts.
//   IDLE: o_busy=0, o_first=0, o_done=0, o_serial=IDLE_LEVEL.
// TESTING (N=8 unless stated)
//   1 Reset: rst pulse asynchronously between edges -> outputs reset value immediately: o_ready=1, o_busy=0, o_serial=IDLE_LEVEL.
//   2 CPB=1, accept 0x1E MSB_FIRST -> o_serial 0,0,0,1,1,1,1,0 on cycles 1..8.
//     o_first only on cycle 1; o_done on cycle 8; idle on cycle 9.
//   3 CPB=1, accept 0x1E LSB_FIRST -> o_serial 0,1,1,1,1,0,0,0; toggling i_direction mid-frame has no effect.
//   4 CPB=3, accept 0xA5 MSB_FIRST -> each bit held 3 cycles (1,1,1,0,0,0,...); o_busy for 24 cycles; o_done on cycle 24 only.
//   5 CPB=1, i_valid held high with 0xFF then 0x00 -> 8 ones then 8 zeros with no gap.
//     o_ready pulses on cycle 8; o_first on cycles 1 and 9.
//   6 Mid-frame: i_valid with 0x55 during bit 3 is ignored (frame unchanged).
//     Async rst during bit 5 -> outputs reset immediately; next accept starts a fresh frame at bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out converter with a valid/ready handshake.
//   A word is accepted when i_valid & o_ready are high at a rising edge. The
//   word is then shifted out MSB-first or LSB-first, as chosen by i_direction
//   at that moment. Each bit is held for CLKS_PER_BIT clocks. A new word
//   offered during the final clock of a frame is loaded straight away, so
//   frames can follow each other with no gap.
//
// Parameters
//   N            data word width in bits (>= 2)
//   CLKS_PER_BIT clocks each bit is held on o_serial (>= 1)
//   IDLE_LEVEL   level driven on o_serial while no frame is active
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset; any partial frame is dropped
//   i_valid      i_data / i_direction are valid this cycle
//   o_ready      a word can be accepted this cycle
//   i_data       parallel word to serialise
//   i_direction  0 = MSB first, 1 = LSB first; sampled only on accept
//   o_serial     serial bit stream
//   o_first      high for the whole period of bit 0 of each frame
//   o_busy       high while a frame is being shifted out
//   o_done       one-cycle pulse in the final clock of the last bit
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int   N            = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_data,
    input  logic         i_direction,
    output logic         o_serial,
    output logic         o_first,
    output logic         o_busy,
    output logic         o_done
);

    localparam int BW = $clog2(N);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
    localparam logic [DW-1:0] DIV_ZERO = {DW{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    sreg_r;
    logic [N-1:0]    sreg_s;
    logic            dir_r;
    logic            dir_s;
    logic [BW-1:0]   bit_cnt_r;
    logic [BW-1:0]   bit_cnt_s;
    logic [DW-1:0]   div_cnt_r;
    logic [DW-1:0]   div_cnt_s;
    logic            last_s;
    logic            ready_s;
    logic            accept_s;

    // Frame-end and handshake decode, derived only from registered state.
    always_comb begin
        last_s   = (state_r == SHIFT) && (bit_cnt_r == BIT_LAST) && (div_cnt_r == DIV_LAST);
        ready_s  = (state_r == IDLE) || last_s;
        accept_s = i_valid && ready_s;
    end

    // Next-state, shift-register and counter update logic.
    always_comb begin
        state_s   = state_r;
        sreg_s    = sreg_r;
        dir_s     = dir_r;
        bit_cnt_s = bit_cnt_r;
        div_cnt_s = div_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = SHIFT;
                    sreg_s    = i_data;
                    dir_s     = i_direction;
                    bit_cnt_s = BIT_ZERO;
                    div_cnt_s = DIV_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    // Reload on the last clock keeps the stream gapless.
                    if (accept_s) begin
                        state_s   = SHIFT;
                        sreg_s    = i_data;
                        dir_s     = i_direction;
                        bit_cnt_s = BIT_ZERO;
                        div_cnt_s = DIV_ZERO;
                    end else begin
                        state_s   = IDLE;
                        sreg_s    = {N{1'b0}};
                        bit_cnt_s = BIT_ZERO;
                        div_cnt_s = DIV_ZERO;
                    end
                end else if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = DIV_ZERO;
                    bit_cnt_s = bit_cnt_r + BW'(1);
                    if (dir_r) begin
                        sreg_s = {1'b0, sreg_r[N-1:1]};
                    end else begin
                        sreg_s = {sreg_r[N-2:0], 1'b0};
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            default: begin
                state_s   = IDLE;
                sreg_s    = {N{1'b0}};
                dir_s     = 1'b0;
                bit_cnt_s = BIT_ZERO;
                div_cnt_s = DIV_ZERO;
            end
        endcase
    end

    // State, data and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            sreg_r    <= {N{1'b0}};
            dir_r     <= 1'b0;
            bit_cnt_r <= BIT_ZERO;
            div_cnt_r <= DIV_ZERO;
        end else begin
            state_r   <= state_s;
            sreg_r    <= sreg_s;
            dir_r     <= dir_s;
            bit_cnt_r <= bit_cnt_s;
            div_cnt_r <= div_cnt_s;
        end
    end

    // Output decode; every output depends only on registered state.
    always_comb begin
        o_ready  = ready_s;
        o_done   = last_s;
        o_busy   = 1'b0;
        o_first  = 1'b0;
        o_serial = IDLE_LEVEL;
        case (state_r)
            SHIFT: begin
                o_busy   = 1'b1;
                o_first  = (bit_cnt_r == BIT_ZERO);
                o_serial = dir_r ? sreg_r[0] : sreg_r[N-1];
            end
            IDLE: begin
                o_busy   = 1'b0;
                o_first  = 1'b0;
                o_serial = IDLE_LEVEL;
            end
            default: begin
                o_busy   = 1'b0;
                o_first  = 1'b0;
                o_serial = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_direction;
    logic       sel;        // 0: CPB=1 / idle 0 instance, 1: CPB=3 / idle 1 instance

    logic rdy1, ser1, fst1, bsy1, dn1;
    logic rdy3, ser3, fst3, bsy3, dn3;
    logic v1, v3;

    assign v1 = i_valid & ~sel;
    assign v3 = i_valid & sel;

    piso_serializer #(.N(8), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(rdy1), .i_data(i_data),
        .i_direction(i_direction), .o_serial(ser1), .o_first(fst1), .o_busy(bsy1), .o_done(dn1)
    );

    piso_serializer #(.N(8), .CLKS_PER_BIT(3), .IDLE_LEVEL(1'b1)) dut3 (
        .clk(clk), .rst(rst), .i_valid(v3), .o_ready(rdy3), .i_data(i_data),
        .i_direction(i_direction), .o_serial(ser3), .o_first(fst3), .o_busy(bsy3), .o_done(dn3)
    );

    logic rdy, ser, fst, bsy, dn;
    assign rdy = sel ? rdy3 : rdy1;
    assign ser = sel ? ser3 : ser1;
    assign fst = sel ? fst3 : fst1;
    assign bsy = sel ? bsy3 : bsy1;
    assign dn  = sel ? dn3  : dn1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic serial;
        logic first;
        logic done;
    } exp_t;

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       dir;
        logic [7:0] stream;   // expected line bits, leftmost is sent first
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic cur_ready = 1'b1;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic idle_level();
        return sel ? 1'b1 : 1'b0;
    endfunction

    task automatic push_frame(input logic [7:0] stream);
        int   cpb;
        exp_t e;
        cpb = sel ? 3 : 1;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < cpb; c++) begin
                e.serial = stream[7-i];
                e.first  = (i == 0);
                e.done   = (i == 7) && (c == cpb - 1);
                sb.push_back(e);
            end
        end
    endtask

    // One clock: sample after the edge and compare against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("serial", ser, e.serial);
            check("first", fst, e.first);
            check("done", dn, e.done);
            check("busy", bsy, 1'b1);
            cur_ready = e.done;
        end else begin
            check("idle_serial", ser, idle_level());
            check("idle_first", fst, 1'b0);
            check("idle_done", dn, 1'b0);
            check("idle_busy", bsy, 1'b0);
            cur_ready = 1'b1;
        end
        check("ready", rdy, cur_ready);
    endtask

    // Present a word for the next edge; the frame is expected only if ready.
    task automatic offer(input logic [7:0] data, input logic dir,
                         input logic [7:0] stream, output logic took);
        i_valid     = 1'b1;
        i_data      = data;
        i_direction = dir;
        took        = cur_ready;
        if (cur_ready) push_frame(stream);
    endtask

    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        check("rst_ready", rdy, 1'b1);
        check("rst_busy", bsy, 1'b0);
        check("rst_serial", ser, idle_level());
        check("rst_first", fst, 1'b0);
        check("rst_done", dn, 1'b0);
        sb.delete();
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[6];
    logic took;

    initial begin
        vecs[0] = '{sel: 1'b0, data: 8'h1E, dir: 1'b0, stream: 8'b0001_1110};
        vecs[1] = '{sel: 1'b0, data: 8'h1E, dir: 1'b1, stream: 8'b0111_1000};
        vecs[2] = '{sel: 1'b1, data: 8'hA5, dir: 1'b0, stream: 8'b1010_0101};
        vecs[3] = '{sel: 1'b1, data: 8'h1E, dir: 1'b1, stream: 8'b0111_1000};
        vecs[4] = '{sel: 1'b0, data: 8'h80, dir: 1'b1, stream: 8'b0000_0001};
        vecs[5] = '{sel: 1'b0, data: 8'hC3, dir: 1'b0, stream: 8'b1100_0011};

        rst         = 1'b1;
        sel         = 1'b0;
        i_valid     = 1'b0;
        i_data      = 8'h00;
        i_direction = 1'b0;

        // Reset values before any clock edge.
        #3;
        check("por_ready", rdy, 1'b1);
        check("por_busy", bsy, 1'b0);
        check("por_serial", ser, 1'b0);
        sel = 1'b1;
        #1;
        check("por_serial_idle1", ser, 1'b1);
        sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Asynchronous reset pulse between edges while idle.
        async_reset_check();
        tick();

        // Table of single frames; direction and data wiggle mid-frame, and
        // i_valid is raised only while not ready so it must be ignored.
        for (int v = 0; v < 6; v++) begin
            sel = vecs[v].sel;
            tick();
            offer(vecs[v].data, vecs[v].dir, vecs[v].stream, took);
            check("accept_model", took, 1'b1);
            tick();
            for (int c = 0; c < 8 * (sel ? 3 : 1) + 1; c++) begin
                i_direction = ~i_direction;
                i_data      = 8'($urandom);
                i_valid     = ~cur_ready & c[0];
                tick();
            end
            i_valid = 1'b0;
        end

        // Gapless back-to-back: 0xFF then 0x00 with i_valid held high.
        sel = 1'b0;
        tick();
        offer(8'hFF, 1'b0, 8'hFF, took);
        tick();
        took = 1'b0;
        for (int c = 0; c < 12 && !took; c++) begin
            offer(8'h00, 1'b0, 8'h00, took);
            tick();
        end
        check("b2b_second_taken", took, 1'b1);
        i_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();

        // Gapless on the CPB=3 instance too.
        sel = 1'b1;
        tick();
        offer(8'h0F, 1'b1, 8'hF0, took);
        tick();
        took = 1'b0;
        for (int c = 0; c < 30 && !took; c++) begin
            offer(8'h81, 1'b0, 8'h81, took);
            tick();
        end
        check("b2b3_second_taken", took, 1'b1);
        i_valid = 1'b0;
        for (int c = 0; c < 26; c++) tick();

        // Mid-frame ignored valid at bit 3, then async reset during bit 5.
        sel = 1'b0;
        tick();
        offer(8'hA5, 1'b0, 8'b1010_0101, took);
        tick();                         // bit 0
        i_valid = 1'b0;
        tick();                         // bit 1
        tick();                         // bit 2
        tick();                         // bit 3
        i_valid = 1'b1;
        i_data  = 8'h55;
        tick();                         // bit 4, 0x55 must not have been taken
        i_valid = 1'b0;
        tick();                         // bit 5
        async_reset_check();
        tick();
        offer(8'h1E, 1'b0, 8'b0001_1110, took);
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 9; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
